// File: rtl/plru_victim_sel.sv
// Tree pseudo-LRU victim selector: per-set binary tree, lowest-invalid-way override.
// Latency: VictimWay is registered one cycle after CacheSet/ValidWay; Stall holds it and blocks tree writes.
module plru_victim_sel #(
    parameter int NUMWAYS = 4,
    parameter int SETLEN  = 7,
    localparam int LOGW   = $clog2(NUMWAYS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                Stall,
    input  logic [SETLEN-1:0]   CacheSet,
    input  logic [NUMWAYS-1:0]  HitWay,
    input  logic [NUMWAYS-1:0]  ValidWay,
    input  logic                LRUWriteEn,
    input  logic                InvalidateAll,
    output logic [LOGW-1:0]     VictimWay
);
    localparam int NSETS = 2 ** SETLEN;
    localparam int NODES = NUMWAYS - 1;

    typedef logic [NODES-1:0] tree_t;

    tree_t           tree_q [NSETS];
    logic [LOGW-1:0] victim_q, victim_d;
    logic [LOGW-1:0] hit_idx, first_inv;
    logic            any_inv, do_wr;
    tree_t           row_cur, row_upd, row_d;

    // Point every node on the accessed way's path toward the other half.
    function automatic tree_t tree_touch(input tree_t t, input logic [LOGW-1:0] w);
        tree_t r;
        int    n;
        r = t;
        n = 0;
        for (int l = LOGW - 1; l >= 0; l--) begin
            r[n] = ~w[l];
            n    = 2 * n + 1 + int'(w[l]);
        end
        return r;
    endfunction

    function automatic logic [LOGW-1:0] tree_walk(input tree_t t);
        logic [LOGW-1:0] v;
        int              n;
        v = '0;
        n = 0;
        for (int l = LOGW - 1; l >= 0; l--) begin
            v[l] = t[n];
            n    = 2 * n + 1 + int'(v[l]);
        end
        return v;
    endfunction

    always_comb begin
        hit_idx   = '0;
        first_inv = '0;
        any_inv   = ~&ValidWay;
        for (int i = 0; i < NUMWAYS; i++) begin
            if (HitWay[i]) hit_idx = hit_idx | LOGW'(i);
        end
        for (int i = NUMWAYS - 1; i >= 0; i--) begin
            if (!ValidWay[i]) first_inv = LOGW'(i);
        end
    end

    // Lookup sees the post-write row of the same set (write-first bypass).
    always_comb begin
        do_wr   = LRUWriteEn && !Stall && (|HitWay);
        row_cur = tree_q[CacheSet];
        row_upd = tree_touch(row_cur, hit_idx);
        if (InvalidateAll)
            row_d = '0;
        else if (do_wr)
            row_d = row_upd;
        else
            row_d = row_cur;
        if (Stall)
            victim_d = victim_q;
        else if (any_inv)
            victim_d = first_inv;
        else
            victim_d = tree_walk(row_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < NSETS; s++) tree_q[s] <= '0;
            victim_q <= '0;
        end else begin
            if (InvalidateAll) begin
                for (int s = 0; s < NSETS; s++) tree_q[s] <= '0;
            end else if (do_wr) begin
                tree_q[CacheSet] <= row_upd;
            end
            victim_q <= victim_d;
        end
    end

    assign VictimWay = victim_q;

    a_hit_onehot: assert property (@(posedge clk) disable iff (reset)
        (LRUWriteEn && !Stall) |-> $onehot0(HitWay));

endmodule
